// File: rtl/dm_arb.sv
// dm_arb -- data-memory port arbiter and access sequencer.
//
// Shares one data-memory port between the core load/store path (core_*) and
// an external loader/debug master (ext_*). Each access occupies the port for
// MEM_LAT cycles; completion raises a one-cycle ack to the owner and, for
// loads, updates the owner's registered rdata.
//
// Ports:
//   clk, rst_f              clock, synchronous active-high reset
//   core_req/we/addr/wdata  core access request (req held until core_ack)
//   core_rdata, core_ack    core load data / completion pulse
//   core_stall              core_req & ~core_ack, freezes core PC/IR load
//   ext_*                   same set for the external master (no stall)
//   dm_addr/wdata/we        memory port outputs (zero while idle)
//   dm_rdata                memory read data, valid in last access cycle
//   busy                    high while a grant is in progress
module dm_arb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CORE = 2'd1,
    GNT_EXT  = 2'd2
  } state_t;

  state_t              state_reg;
  logic                last_grant_reg;  // 1 = ext was granted last
  logic [ADDR_W-1:0]   a_reg;
  logic                we_reg;
  logic [DATA_W-1:0]   wd_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                first_reg;

  // Per-requester vectors: bit 0 = core, bit 1 = ext.
  logic [1:0]          req_vec;
  logic [1:0]          ack_vec;
  logic [1:0]          elig;
  logic [1:0]          owner_vec;
  logic [2*DATA_W-1:0] rdata_vec;
  logic                pick_ext;
  logic                done;

  assign req_vec = {ext_req, core_req};
  // A requester whose ack is still high is masked so a held req is not
  // served a second time.
  assign elig    = req_vec & ~ack_vec;
  // Ext wins when it is the only one eligible, or on a tie when core was
  // granted last.
  assign pick_ext  = elig[1] & (~elig[0] | ~last_grant_reg);
  assign done      = (state_reg != IDLE) && (cnt_reg == '0);
  assign owner_vec = {state_reg == GNT_EXT, state_reg == GNT_CORE};

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      we_reg         <= 1'b0;
      wd_reg         <= '0;
      cnt_reg        <= '0;
      first_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|elig) begin
            state_reg      <= pick_ext ? GNT_EXT : GNT_CORE;
            last_grant_reg <= pick_ext;
            a_reg          <= pick_ext ? ext_addr  : core_addr;
            we_reg         <= pick_ext ? ext_we    : core_we;
            wd_reg         <= pick_ext ? ext_wdata : core_wdata;
            cnt_reg        <= CNT_LOAD;
            first_reg      <= 1'b1;
          end
        end
        default: begin
          first_reg <= 1'b0;
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  // Completion side per requester: one-cycle ack and load-data capture.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic              ack_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (rst_f) begin
          ack_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ack_reg <= done & owner_vec[gi];
          if (done && owner_vec[gi] && !we_reg) begin
            rdata_reg <= dm_rdata;
          end
        end
      end

      assign ack_vec[gi]                    = ack_reg;
      assign rdata_vec[gi*DATA_W +: DATA_W] = rdata_reg;
    end
  endgenerate

  assign busy       = (state_reg != IDLE);
  assign dm_addr    = busy ? a_reg  : '0;
  assign dm_wdata   = busy ? wd_reg : '0;
  // Gated by first_reg so a multi-cycle store writes once; gated by rst_f
  // so a store starting under reset never reaches memory.
  assign dm_we      = busy & we_reg & first_reg & ~rst_f;

  assign core_ack   = ack_vec[0];
  assign ext_ack    = ack_vec[1];
  assign core_rdata = rdata_vec[0 +: DATA_W];
  assign ext_rdata  = rdata_vec[DATA_W +: DATA_W];
  assign core_stall = core_req & ~ack_vec[0];

endmodule

// File: doc/dm_arb.md
# dm_arb

Data-memory port arbiter and access sequencer for the SISC processor. It shares the single data-memory port between two requesters: the core load/store path (`core_*`) and an external loader/debug master (`ext_*`). It sequences each access over a configurable memory latency and returns read data with a one-cycle acknowledge. It sits between the core's address/store-data path and `dm`, replacing the direct core-to-`dm` connection.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: number of cycles a memory access occupies the port; legal range 1..7.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_f`  in  1  reset; synchronous, active-high.
- `core_req`  in  1  core access request; held until `core_ack`.
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  ADDR_W  core address.
- `core_wdata`  in  DATA_W  core store data.
- `core_rdata`  out  DATA_W  registered load data; valid while `core_ack`=1.
- `core_ack`  out  1  one-cycle completion pulse.
- `core_stall`  out  1  `core_req & ~core_ack`; combinational; freezes the core's PC/IR load.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_rdata`, `ext_ack`: same semantics as the core set, for the external master.
- `dm_addr`  out  ADDR_W  memory address.
- `dm_wdata`  out  DATA_W  memory write data.
- `dm_we`  out  1  memory write strobe.
- `dm_rdata`  in  DATA_W  memory read data; valid in the last cycle of an access.
- `busy`  out  1  high while the arbiter is in GNT_CORE or GNT_EXT.

## Operation
- The arbiter has three states: IDLE, GNT_CORE, GNT_EXT.
- **Eligibility:** a requester is eligible when its `req`=1 and its `ack`=0. This prevents one held request from being served twice.
- **Arbitration in IDLE:**
  - Exactly one eligible requester: it is granted.
  - Both eligible: the requester that was not granted last wins.
  - `last_grant` updates on every grant and resets to EXT, so the core wins the first tie.
- **On a grant edge:**
  - `addr`, `we` and `wdata` of the winner are latched into `a_reg`, `we_reg` and `wd_reg`.
  - `cnt` loads MEM_LAT-1.
  - `first` is set to 1.
- **During a grant state:**
  - `dm_addr` = `a_reg` and `dm_wdata` = `wd_reg`.
  - `dm_we` = `we_reg & first & ~rst_f`, so exactly one write pulse is issued per store regardless of MEM_LAT.
  - `first` clears after the first cycle.
  - `cnt` decrements each cycle.
- **Completion:** on the edge where `cnt`==0 and the access is a load, `dm_rdata` is captured into the owner's `rdata` register. On that same edge the owner's `ack` is set for one cycle (load or store) and the state returns to IDLE.
- **Store `rdata`:** a store leaves the owner's `rdata` register unchanged.
- **Outputs in IDLE:** `dm_addr`=0, `dm_wdata`=0, `dm_we`=0.
- **Unrequested requester:** a requester that is not requesting is never granted. A request that drops before it is granted is discarded.

## Timing
- **Reset values:**
  - State=IDLE; both `ack`=0; `core_rdata`=`ext_rdata`=0.
  - `dm_we`=0, `dm_addr`=0, `dm_wdata`=0.
  - `busy`=0; `last_grant`=EXT; `cnt`=0.
- **Latency:**
  - The request is sampled at edge E0 and the grant state holds for cycles E0..E0+MEM_LAT-1.
  - `ack` is high in the cycle following edge E0+MEM_LAT.
  - Request to ack is MEM_LAT+1 edges.
- **Back-to-back:**
  - The arbiter is in IDLE during the ack cycle.
  - The other requester, if eligible, is granted at the edge ending the ack cycle.
  - The just-acked requester becomes eligible again only once its `ack` has fallen. The requester drops `req` at the ack edge if it has no further access.
- **Throughput:** one access per MEM_LAT+1 cycles.
- **Reset mid-access:**
  - `dm_we` is forced low immediately (combinational gate).
  - State returns to IDLE at the next edge, with no ack and no `rdata` update.
  - A store whose first cycle coincides with `rst_f`=1 is not written.
- **Input change during a grant:** a requester changing `addr`/`wdata` while granted has no effect, because the latched values are used.

## Test plan
- **Single core load, MEM_LAT=1, `dm[0x0010]`=0xDEADBEEF:** assert `core_req`/`addr`=0x0010/`we`=0. Required: `dm_addr`=0x0010 for 1 cycle, `core_ack` one cycle later, `core_rdata`=0xDEADBEEF, `core_stall` high for 2 cycles.
- **Both requesting continuously after reset:** grants alternate CORE, EXT, CORE, EXT. No requester is granted twice in a row and no ack lasts more than one cycle.
- **Ext then core, same address:** ext store 0x12345678 to 0x0042, then core load 0x0042. Required: `core_rdata`=0x12345678.
- **MEM_LAT=3 store:** `dm_we` high exactly one cycle, `busy` high 3 cycles, `ack` on the 4th cycle after the request edge.
- **Reset asserted in the 2nd cycle of a MEM_LAT=3 ext load:** no `ext_ack`, `ext_rdata` stays 0, state is IDLE next cycle, and `busy`=0.
- **Core holds `req` one extra cycle after its ack with `ext_req`=0:** no second grant occurs. `busy` stays 0 once `req` drops.
